// File: rtl/tcp_pkg.sv
// Shared TCP transmit-path definitions: FSM encodings, payload limit, buffer selects.
// Also holds the helper that left-aligns a partial packed word.
package tcp_pkg;

    localparam int TCP_MAX_PAYLOAD = 1450;

    localparam logic [2:0] ST_SEL   = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam logic [1:0] BUF_A = 2'b01;
    localparam logic [1:0] BUF_B = 2'b10;

    // w holds n valid bytes in its low end; move them to the top, zero-fill below.
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd1:    r = {w[7:0], 24'h0};
            2'd2:    r = {w[15:0], 16'h0};
            2'd3:    r = {w[23:0], 8'h0};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tcp_chksum_acc.sv
// 16-bit ones-complement accumulator: clear, add one word with end-around carry folded immediately.
// Sum updates one cycle after add; clr wins over add.
module tcp_chksum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] sum
);

    logic [16:0] raw;

    assign raw = {1'b0, sum} + {1'b0, word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 16'h0000;
        end else if (clr) begin
            sum <= 16'h0000;
        end else if (add) begin
            sum <= raw[15:0] + {15'h0, raw[16]};
        end
    end

endmodule

// File: rtl/tcp_payload_packer.sv
// Packs a byte stream big-endian into 32-bit words for two ping-pong TX buffers, tracking length and payload sum.
// Optional idle-flush of partial packets under `FLUSH_TIMEOUT_EN; stop strobe is registered, seen during HOLD.
module tcp_payload_packer
    import tcp_pkg::*;
#(
    parameter int MAX_PACKET_SIZE = TCP_MAX_PAYLOAD
`ifdef FLUSH_TIMEOUT_EN
    ,parameter int FLUSH_CYCLES   = 125000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [31:0] wdat_o,
    output logic        wr_o,
    output logic [1:0]  wr_sel_o,
    output logic        wr_op_stop_o,
    output logic [15:0] wdat_len_o,
    output logic [15:0] wdat_chksum_o,
    input  logic [1:0]  wr_lock_flg_i
);

    logic [2:0]  state;
    logic [15:0] len;
    logic [1:0]  bcnt;
    logic [23:0] word_sr;
    logic [7:0]  hi_byte;
    logic        accept;
    logic [15:0] len_nxt;
    logic [1:0]  bcnt_nxt;
    logic [31:0] cur_word;
    logic        close_byte;
    logic        timeout_close;
    logic        acc_add;
    logic [15:0] acc_word;
    logic [15:0] acc_sum;

    assign s_ready_o  = (state == ST_FILL);
    assign accept     = s_valid_i & s_ready_o;
    assign len_nxt    = len + 16'd1;
    assign bcnt_nxt   = bcnt + 2'd1;
    assign cur_word   = {word_sr, s_data_i};
    assign close_byte = accept & (s_last_i | (len_nxt == 16'(MAX_PACKET_SIZE)));

`ifdef FLUSH_TIMEOUT_EN
    localparam int IW = $clog2(FLUSH_CYCLES + 1);
    logic [IW-1:0] idle_cnt;

    assign timeout_close = (state == ST_FILL) && !accept && (len != 16'd0)
                           && (idle_cnt == IW'(FLUSH_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != ST_FILL || accept || len == 16'd0) begin
            idle_cnt <= '0;
        end else if (!timeout_close) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_close = 1'b0;
`endif

    // Odd-index bytes complete a 16-bit pair; an odd-length packet adds its lone high byte on close.
    always_comb begin
        acc_add  = 1'b0;
        acc_word = 16'h0000;
        if (accept) begin
            if (len[0]) begin
                acc_add  = 1'b1;
                acc_word = {hi_byte, s_data_i};
            end else if (close_byte) begin
                acc_add  = 1'b1;
                acc_word = {s_data_i, 8'h00};
            end
        end else if (timeout_close && len[0]) begin
            acc_add  = 1'b1;
            acc_word = {hi_byte, 8'h00};
        end
    end

    tcp_chksum_acc u_chksum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_STOP),
        .add   (acc_add),
        .word  (acc_word),
        .sum   (acc_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_SEL;
            len           <= 16'd0;
            bcnt          <= 2'd0;
            word_sr       <= 24'h0;
            hi_byte       <= 8'h00;
            wdat_o        <= 32'h0;
            wr_o          <= 1'b0;
            wr_sel_o      <= BUF_A;
            wr_op_stop_o  <= 1'b0;
            wdat_len_o    <= 16'd0;
            wdat_chksum_o <= 16'h0000;
        end else begin
            wr_o         <= 1'b0;
            wr_op_stop_o <= 1'b0;
            case (state)
                ST_SEL: begin
                    if (~|(wr_lock_flg_i & wr_sel_o)) state <= ST_FILL;
                end
                ST_FILL: begin
                    if (accept) begin
                        len     <= len_nxt;
                        bcnt    <= bcnt_nxt;
                        word_sr <= cur_word[23:0];
                        if (!len[0]) hi_byte <= s_data_i;
                        // Full word or closing partial word goes out next cycle.
                        if (bcnt_nxt == 2'd0 || close_byte) begin
                            wdat_o <= pad_word(cur_word, bcnt_nxt);
                            wr_o   <= 1'b1;
                        end
                        if (close_byte) state <= (bcnt_nxt == 2'd0) ? ST_STOP : ST_FLUSH;
                    end else if (timeout_close) begin
                        if (bcnt != 2'd0) begin
                            wdat_o <= pad_word({8'h00, word_sr}, bcnt);
                            wr_o   <= 1'b1;
                        end
                        state <= (bcnt == 2'd0) ? ST_STOP : ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_STOP;
                end
                ST_STOP: begin
                    wr_op_stop_o  <= 1'b1;
                    wdat_len_o    <= len;
                    wdat_chksum_o <= acc_sum;
                    len           <= 16'd0;
                    bcnt          <= 2'd0;
                    state         <= ST_HOLD;
                end
                ST_HOLD: begin
                    wr_sel_o <= {wr_sel_o[0], wr_sel_o[1]};
                    state    <= ST_SEL;
                end
                default: state <= ST_SEL;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_payload_packer.sv
// Directed bench for tcp_payload_packer: packing, flush, checksum fold, ping-pong, locks, max size, reset.
module tb_tcp_payload_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] wdat;
    logic        wr;
    logic [1:0]  wr_sel;
    logic        wr_op_stop;
    logic [15:0] wdat_len;
    logic [15:0] wdat_chksum;
    logic [1:0]  wr_lock_flg;

    int vectors = 0;
    int errs    = 0;
    int collisions = 0;
    int selbad  = 0;

    logic [33:0] wq[$];
    logic [33:0] sq[$];
    logic [7:0]  txq[$];

    tcp_payload_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data_i      (s_data),
        .s_valid_i     (s_valid),
        .s_last_i      (s_last),
        .s_ready_o     (s_ready),
        .wdat_o        (wdat),
        .wr_o          (wr),
        .wr_sel_o      (wr_sel),
        .wr_op_stop_o  (wr_op_stop),
        .wdat_len_o    (wdat_len),
        .wdat_chksum_o (wdat_chksum),
        .wr_lock_flg_i (wr_lock_flg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr) wq.push_back({wr_sel, wdat});
            if (wr_op_stop) sq.push_back({wr_sel, wdat_len, wdat_chksum});
            if (wr && wr_op_stop) collisions++;
            if (wr && ((wr_sel != 2'b01) && (wr_sel != 2'b10))) selbad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit last_on_end);
        int i = 0;
        int guard = 0;
        logic acc;
        while (i < txq.size() && guard < 5000) begin
            @(negedge clk);
            s_data  = txq[i];
            s_valid = 1'b1;
            s_last  = last_on_end && (i == txq.size() - 1);
            acc     = s_ready;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        check("send_done", 64'(i), 64'(txq.size()));
    endtask

    task automatic wait_stops(input int n);
        int g = 0;
        while (sq.size() < n && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("stop_seen", 64'(sq.size() >= n), 64'd1);
    endtask

    // Plain 32-bit sum of big-endian byte pairs, folded once at the end.
    function automatic logic [15:0] ref_sum(input int n);
        logic [31:0] s = 0;
        logic [7:0]  hi;
        logic [7:0]  lo;
        for (int i = 0; i < n; i += 2) begin
            hi = 8'(i);
            lo = (i + 1 < n) ? 8'(i + 1) : 8'h00;
            s  = s + {16'h0, hi, lo};
        end
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return s[15:0];
    endfunction

    initial begin
        rst_n = 1'b0;
        s_data = 8'h00;
        s_valid = 1'b0;
        s_last = 1'b0;
        wr_lock_flg = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_wr", 64'(wr), 64'd0);
        check("rst_stop", 64'(wr_op_stop), 64'd0);
        check("rst_sel", 64'(wr_sel), 64'h1);
        check("rst_wdat", 64'(wdat), 64'h0);
        check("rst_len", 64'(wdat_len), 64'h0);
        check("rst_chk", 64'(wdat_chksum), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five bytes: one full word plus a flushed partial word
        txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send(1'b1);
        wr_lock_flg = 2'b11;
        wait_stops(1);
        check("t1_nwords", 64'(wq.size()), 64'd2);
        check("t1_word0", 64'(wq[0]), 64'h1_0102_0304);
        check("t1_word1", 64'(wq[1]), 64'h1_0500_0000);
        check("t1_stop", 64'(sq[0]), {30'h0, 2'b01, 16'd5, 16'h0906});

        // Both buffers locked: hold off, then free buffer B
        repeat (4) @(negedge clk);
        #1;
        check("t4_ready_locked", 64'(s_ready), 64'd0);
        check("t4_sel_b", 64'(wr_sel), 64'h2);
        @(negedge clk);
        wr_lock_flg = 2'b01;
        #1;
        check("t4_still_idle", 64'(s_ready), 64'd0);
        @(negedge clk);
        #1;
        check("t4_ready_b", 64'(s_ready), 64'd1);

        // Carry fold, full word closes without a flush cycle
        wq.delete();
        sq.delete();
        txq = '{8'hFF, 8'hFF, 8'h00, 8'h01};
        send(1'b1);
        check("t2_wr_latency", 64'(wr), 64'd1);
        check("t2_wdat", 64'(wdat), 64'hFFFF_0001);
        wr_lock_flg = 2'b00;
        wait_stops(1);
        check("t2_nwords", 64'(wq.size()), 64'd1);
        check("t2_word_sel", 64'(wq[0]), 64'h2_FFFF_0001);
        check("t2_stop", 64'(sq[0]), {30'h0, 2'b10, 16'd4, 16'h0001});

        // Continuous stream past the size limit
        wq.delete();
        sq.delete();
        txq.delete();
        for (int i = 0; i < 1452; i++) txq.push_back(8'(i));
        send(1'b0);
        repeat (10) @(negedge clk);
        #1;
        check("t3_nstops", 64'(sq.size()), 64'd1);
        check("t3_stop", 64'(sq[0]), {30'h0, 2'b01, 16'd1450, ref_sum(1450)});
        check("t3_nwords", 64'(wq.size()), 64'd363);
        check("t3_first", 64'(wq[0]), 64'h1_0001_0203);
        check("t3_full_last", 64'(wq[361]), 64'h1_A4A5_A6A7);
        check("t3_flush", 64'(wq[362]), 64'h1_A8A9_0000);
        check("t3_sel_b", 64'(wr_sel), 64'h2);
        check("t3_b_filling", 64'(s_ready), 64'd1);

        // Third byte into buffer B, then reset mid-packet
        txq = '{8'h77};
        send(1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_ready", 64'(s_ready), 64'd0);
        check("t5_wr", 64'(wr), 64'd0);
        check("t5_sel", 64'(wr_sel), 64'h1);
        check("t5_stop", 64'(wr_op_stop), 64'd0);
        check("t5_no_b_word", 64'(wq.size()), 64'd363);
        check("t5_no_b_stop", 64'(sq.size()), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        sq.delete();
        txq = '{8'h01, 8'h02};
        send(1'b1);
        wait_stops(1);
        check("t5_new_word", 64'(wq[0]), 64'h1_0102_0000);
        check("t5_new_stop", 64'(sq[0]), {30'h0, 2'b01, 16'd2, 16'h0102});

        repeat (3) @(negedge clk);
        check("no_wr_stop_overlap", 64'(collisions), 64'd0);
        check("wr_sel_onehot", 64'(selbad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
